sram_req_bridge: RTL and testbench
==================================

// Module: sram_req_bridge
// PURPOSE
//  Converts the core's valid/ready memory request channel into the single-port SRAM strobe interface consumed by sram_xbar.
//  Decodes each request into one of two SRAM regions and drives the xbar select (slave_mux_in).
//  Captures the 1-cycle-latency SRAM read data into a valid/ready response channel, holding it under back-pressure.
//  Address misses complete with an error response and no SRAM strobe.
// PARAMETERS
//  LEN_ADDR   32            address width, byte address on req side
//  LEN_DATA   32            data width; LEN_DATA/8 byte strobes
//  R0_BASE    32'h8000_0000 region 0 (xbar slave0) byte base, aligned to R0_SIZE
//  R0_SIZE    32'h0001_0000 region 0 size in bytes, power of two
//  R1_BASE    32'h8001_0000 region 1 (xbar slave1) byte base, aligned to R1_SIZE
//  R1_SIZE    32'h0001_0000 region 1 size in bytes, power of two
// PORTS
//  clk          in   1            clock, all state on rising edge
//  rst_n        in   1            asynchronous active-low reset
//  req_valid    in   1            request present
//  req_ready    out  1            bridge accepts request this cycle
//  req_write    in   1            1 = write, 0 = read
//  req_addr     in   LEN_ADDR     byte address
//  req_wdata    in   LEN_DATA     write data
//  req_wstrb    in   LEN_DATA/8   byte write enables (ignored for reads)
//  resp_valid   out  1            response present
//  resp_ready   in   1            consumer accepts response
//  resp_rdata   out  LEN_DATA     read data; 0 for writes and errors
//  resp_err     out  1            request hit neither region
//  sram_mux     out  1            to xbar slave_mux_in: 0 = region 0, 1 = region 1
//  sram_addra   out  LEN_ADDR     word address = (req_addr - region base) >> log2(LEN_DATA/8)
//  sram_dina    out  LEN_DATA     = req_wdata
//  sram_ena     out  1            SRAM enable
//  sram_wea     out  LEN_DATA/8   = req_wstrb when write, else 0
//  sram_douta   in   LEN_DATA     from xbar master_douta, valid 1 cycle after ena
// BEHAVIOUR
//  Reset (async assert, sync release): pend=0, hold_v=0, pend_err=0, pend_wr=0; resp_valid=0, resp_err=0, resp_rdata=0.
//  Reset mid-transaction discards the outstanding access/response; no replay.
//  Handshake: fire = req_valid & req_ready; resp done = resp_valid & resp_ready. Valid never drops without a handshake; payload stable while stalled.
//  req_ready = !hold_v & (!pend | resp_ready); one access outstanding max; full throughput (1 req/cycle) when resp_ready=1.
//  Decode (comb, from req_addr): hit0 = addr in [R0_BASE, R0_BASE+R0_SIZE); hit1 likewise; sram_mux = hit1.
//  sram_ena = fire & (hit0 | hit1); miss issues no strobe; sram_wea = 0 whenever sram_ena = 0.
//  sram_addra/sram_dina/sram_mux driven combinationally from req for the fire cycle; don't-care otherwise.
//  States (pend, hold_v): IDLE(0,0) -> fire -> PEND(1,0) next cycle.
//  PEND: resp_valid=1 with resp_rdata = pend_wr|pend_err ? 0 : sram_douta (bypass), resp_err=pend_err.
//   resp_ready=1: retire; stays PEND if a new fire in same cycle, else IDLE.
//   resp_ready=0: capture presented rdata/err into hold reg -> HOLD(0,1).
//  HOLD: resp_valid=1 from hold reg, req_ready=0; resp_ready=1 -> IDLE.
//  HOLD capture is mandatory: SRAM/xbar output is not guaranteed stable after the latency cycle.
//  Latency: read/write/err response visible exactly 1 cycle after fire when not stalled.
//  Simultaneous: retire + new fire in PEND is allowed; response order = request order.
//  Addr wrap: region end computed in LEN_ADDR+1 bits; base+size overflow must not alias to low addresses.
// TESTING
//  Read R0 0x8000_0010 (SRAM0 word 4 = 0xDEAD_BEEF), resp_ready=1 -> ena=1,mux=0,addra=4; next cycle resp_valid, rdata=0xDEAD_BEEF.
//  Back-to-back reads 0x8000_0000 then 0x8001_0004, resp_ready=1 -> req_ready stays 1, mux 0 then 1, two responses on consecutive cycles.
//  Read R1, resp_ready=0 for 3 cycles while SRAM douta changes -> rdata held at captured value, req_ready=0 until retire.
//  Write 0x8000_0008 wdata 0x1122_3344 wstrb 4'b0101 -> ena=1, wea=4'b0101, addra=2; response rdata=0, err=0; readback 0x??22_??44.
//  Read 0x9000_0000 -> ena=0, wea=0; next cycle resp_valid=1, resp_err=1, rdata=0.
//  Assert rst_n=0 in PEND and in HOLD -> resp_valid=0 immediately (async); after release req_ready=1, no stale response.

Source files
------------

// File: rtl/sram_req_bridge.sv
// sram_req_bridge: valid/ready request channel to dual-region SRAM strobes with a held response channel
module sram_req_bridge #(
   parameter int                  LEN_ADDR = 32,
   parameter int                  LEN_DATA = 32,
   parameter logic [LEN_ADDR-1:0] R0_BASE  = 32'h8000_0000,
   parameter logic [LEN_ADDR-1:0] R0_SIZE  = 32'h0001_0000,
   parameter logic [LEN_ADDR-1:0] R1_BASE  = 32'h8001_0000,
   parameter logic [LEN_ADDR-1:0] R1_SIZE  = 32'h0001_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [LEN_ADDR-1:0]   req_addr,
   input  logic [LEN_DATA-1:0]   req_wdata,
   input  logic [LEN_DATA/8-1:0] req_wstrb,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [LEN_DATA-1:0]   resp_rdata,
   output logic                  resp_err,
   output logic                  sram_mux,
   output logic [LEN_ADDR-1:0]   sram_addra,
   output logic [LEN_DATA-1:0]   sram_dina,
   output logic                  sram_ena,
   output logic [LEN_DATA/8-1:0] sram_wea,
   input  logic [LEN_DATA-1:0]   sram_douta
);
   localparam int SH = $clog2(LEN_DATA/8);
   // region ends carry one extra bit so base+size at the top of memory never wraps to zero
   localparam logic [LEN_ADDR:0] R0_END = {1'b0, R0_BASE} + {1'b0, R0_SIZE};
   localparam logic [LEN_ADDR:0] R1_END = {1'b0, R1_BASE} + {1'b0, R1_SIZE};
   typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
   state_t state, state_nx;
   logic pend_err, pend_wr, hold_err, hit0, hit1, fire;
   logic [LEN_DATA-1:0] hold_rdata, pend_rdata;
   logic [LEN_ADDR:0] addr_x;
   logic [LEN_ADDR-1:0] base;
   assign addr_x = {1'b0, req_addr};
   assign hit0 = (addr_x >= {1'b0, R0_BASE}) && (addr_x < R0_END);
   assign hit1 = (addr_x >= {1'b0, R1_BASE}) && (addr_x < R1_END);
   assign base = hit1 ? R1_BASE : R0_BASE;
   assign req_ready = (state == IDLE) || (state == PEND && resp_ready);
   assign fire = req_valid & req_ready;
   assign sram_mux = hit1;
   assign sram_addra = (req_addr - base) >> SH;
   assign sram_dina = req_wdata;
   assign sram_ena = fire & (hit0 | hit1);
   assign sram_wea = (sram_ena & req_write) ? req_wstrb : '0;
   // SRAM data is only valid in the cycle after the strobe, so PEND bypasses it straight out
   assign pend_rdata = (pend_wr | pend_err) ? '0 : sram_douta;
   assign resp_valid = (state == PEND) || (state == HOLD);
   assign resp_rdata = (state == HOLD) ? hold_rdata : (state == PEND) ? pend_rdata : '0;
   assign resp_err = (state == HOLD) ? hold_err : (state == PEND) ? pend_err : 1'b0;
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // next state: a stalled PEND response moves into the hold register
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = fire ? PEND : IDLE;
         PEND: state_nx = !resp_ready ? HOLD : fire ? PEND : IDLE;
         HOLD: state_nx = resp_ready ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   // per-access attributes on fire, response capture when the consumer stalls in PEND
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_err <= 1'b0;
         pend_wr <= 1'b0;
         hold_err <= 1'b0;
         hold_rdata <= '0;
      end else begin
         if (fire) begin
            pend_err <= !(hit0 | hit1);
            pend_wr <= req_write;
         end
         if (state == PEND && !resp_ready) begin
            hold_rdata <= pend_rdata;
            hold_err <= pend_err;
         end
      end
   end
endmodule

// File: tb/tb_sram_req_bridge.sv
// tb_sram_req_bridge: directed checks of the bridge against a 1-cycle-latency SRAM pair
module tb_sram_req_bridge;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, sram_mux, sram_ena;
   logic [31:0] req_addr, req_wdata, resp_rdata, sram_addra, sram_dina, dout;
   logic [3:0] req_wstrb, sram_wea;
   logic [31:0] mem0 [64];
   logic [31:0] mem1 [64];
   logic loaded = 1'b0;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   sram_req_bridge dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .sram_mux(sram_mux),
      .sram_addra(sram_addra), .sram_dina(sram_dina), .sram_ena(sram_ena), .sram_wea(sram_wea),
      .sram_douta(dout)
   );

   // SRAM pair: read-first, 1-cycle latency, output garbage when not enabled
   always @(posedge clk) begin
      if (!loaded) begin
         mem0[0] <= 32'h0101_0101;
         mem0[2] <= 32'hAABB_CCDD;
         mem0[4] <= 32'hDEAD_BEEF;
         mem1[1] <= 32'hCAFE_F00D;
         mem1[63] <= 32'h5A5A_0001;
         loaded <= 1'b1;
      end
      if (sram_ena) begin
         dout <= sram_mux ? mem1[sram_addra[5:0]] : mem0[sram_addra[5:0]];
         for (int b = 0; b < 4; b++)
            if (sram_wea[b]) begin
               if (sram_mux) mem1[sram_addra[5:0]][8*b+:8] <= sram_dina[8*b+:8];
               else mem0[sram_addra[5:0]][8*b+:8] <= sram_dina[8*b+:8];
            end
      end else dout <= $urandom;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b exp 0", resp_err); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h exp 0", resp_rdata); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
      checks++; if (sram_ena !== 1'b0) begin errors++; $display("FAIL rst_ena: got %b exp 0", sram_ena); end
      @(negedge clk);
      rst_n = 1'b1;
      step;
   endtask

   task automatic test_read;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0010; resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b exp 1", req_ready); end
      checks++; if (sram_ena !== 1'b1) begin errors++; $display("FAIL rd_ena: got %b exp 1", sram_ena); end
      checks++; if (sram_mux !== 1'b0) begin errors++; $display("FAIL rd_mux: got %b exp 0", sram_mux); end
      checks++; if (sram_addra !== 32'd4) begin errors++; $display("FAIL rd_addra: got %h exp 4", sram_addra); end
      checks++; if (sram_wea !== 4'b0) begin errors++; $display("FAIL rd_wea: got %b exp 0", sram_wea); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: got %b exp 0", resp_valid); end
      step;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_valid: got %b exp 1", resp_valid); end
      checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h exp deadbeef", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b exp 0", resp_err); end
      step;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd_retire: got %b exp 0", resp_valid); end
      step;
   endtask

   task automatic test_back_to_back;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0000; resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (sram_ena !== 1'b1 || sram_mux !== 1'b0 || sram_addra !== 32'd0) begin errors++; $display("FAIL b2b_first: got ena=%b mux=%b addra=%h exp 1 0 0", sram_ena, sram_mux, sram_addra); end
      step;
      req_addr = 32'h8001_0004;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", req_ready); end
      checks++; if (sram_ena !== 1'b1 || sram_mux !== 1'b1 || sram_addra !== 32'd1) begin errors++; $display("FAIL b2b_second: got ena=%b mux=%b addra=%h exp 1 1 1", sram_ena, sram_mux, sram_addra); end
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0101_0101) begin errors++; $display("FAIL b2b_resp1: got v=%b %h exp 1 01010101", resp_valid, resp_rdata); end
      step;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_resp2: got v=%b %h exp 1 cafef00d", resp_valid, resp_rdata); end
      step;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", resp_valid); end
      step;
   endtask

   task automatic test_hold;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8001_0004; resp_ready = 1'b0;
      @(negedge clk);
      checks++; if (sram_ena !== 1'b1 || sram_mux !== 1'b1) begin errors++; $display("FAIL hold_issue: got ena=%b mux=%b exp 1 1", sram_ena, sram_mux); end
      step;
      req_addr = 32'h8000_0010;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL hold_pend: got v=%b %h exp 1 cafef00d", resp_valid, resp_rdata); end
      checks++; if (req_ready !== 1'b0 || sram_ena !== 1'b0) begin errors++; $display("FAIL hold_pend_block: got ready=%b ena=%b exp 0 0", req_ready, sram_ena); end
      step;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL hold_data[%0d]: got v=%b %h exp 1 cafef00d", i, resp_valid, resp_rdata); end
         checks++; if (req_ready !== 1'b0 || sram_ena !== 1'b0) begin errors++; $display("FAIL hold_block[%0d]: got ready=%b ena=%b exp 0 0", i, req_ready, sram_ena); end
         step;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b0 || resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL hold_retire: got ready=%b %h exp 0 cafef00d", req_ready, resp_rdata); end
      step;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || sram_ena !== 1'b1 || sram_addra !== 32'd4) begin errors++; $display("FAIL hold_next_issue: got v=%b ena=%b addra=%h exp 0 1 4", resp_valid, sram_ena, sram_addra); end
      step;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_next_resp: got v=%b %h exp 1 deadbeef", resp_valid, resp_rdata); end
      step;
   endtask

   task automatic test_write;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0008; req_wdata = 32'h1122_3344; req_wstrb = 4'b0101; resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (sram_ena !== 1'b1 || sram_wea !== 4'b0101 || sram_addra !== 32'd2) begin errors++; $display("FAIL wr_issue: got ena=%b wea=%b addra=%h exp 1 0101 2", sram_ena, sram_wea, sram_addra); end
      checks++; if (sram_dina !== 32'h1122_3344 || sram_mux !== 1'b0) begin errors++; $display("FAIL wr_dina: got %h mux=%b exp 11223344 0", sram_dina, sram_mux); end
      step;
      req_write = 1'b0; req_wstrb = 4'b1111;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL wr_resp: got v=%b %h err=%b exp 1 0 0", resp_valid, resp_rdata, resp_err); end
      checks++; if (sram_ena !== 1'b1 || sram_wea !== 4'b0) begin errors++; $display("FAIL wr_rb_issue: got ena=%b wea=%b exp 1 0000", sram_ena, sram_wea); end
      step;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hAA22_CC44) begin errors++; $display("FAIL wr_readback: got v=%b %h exp 1 aa22cc44", resp_valid, resp_rdata); end
      step;
   endtask

   task automatic test_miss;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h9000_0000; req_wstrb = 4'b1111; resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (sram_ena !== 1'b0 || sram_wea !== 4'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL miss_issue: got ena=%b wea=%b ready=%b exp 0 0 1", sram_ena, sram_wea, req_ready); end
      step;
      req_write = 1'b1; req_addr = 32'h8002_0000;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL miss_resp: got v=%b err=%b %h exp 1 1 0", resp_valid, resp_err, resp_rdata); end
      checks++; if (sram_ena !== 1'b0 || sram_wea !== 4'b0) begin errors++; $display("FAIL miss_end_issue: got ena=%b wea=%b exp 0 0", sram_ena, sram_wea); end
      step;
      req_write = 1'b0; req_addr = 32'h7FFF_FFFC;
      @(negedge clk);
      checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL miss_wr_resp: got err=%b %h exp 1 0", resp_err, resp_rdata); end
      checks++; if (sram_ena !== 1'b0) begin errors++; $display("FAIL miss_below: got ena=%b exp 0", sram_ena); end
      step;
      req_addr = 32'h8001_FFFC;
      @(negedge clk);
      checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL miss_below_resp: got err=%b exp 1", resp_err); end
      checks++; if (sram_ena !== 1'b1 || sram_mux !== 1'b1 || sram_addra !== 32'h3FFF) begin errors++; $display("FAIL top_issue: got ena=%b mux=%b addra=%h exp 1 1 3fff", sram_ena, sram_mux, sram_addra); end
      step;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h5A5A_0001) begin errors++; $display("FAIL top_resp: got err=%b %h exp 0 5a5a0001", resp_err, resp_rdata); end
      step;
   endtask

   task automatic test_reset_mid;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0010; resp_ready = 1'b1;
      step;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rpend_valid: got %b exp 1", resp_valid); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL rpend_async: got v=%b %h exp 0 0", resp_valid, resp_rdata); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rpend_after: got v=%b ready=%b exp 0 1", resp_valid, req_ready); end
      step;
      req_valid = 1'b1; req_addr = 32'h8001_0004; resp_ready = 1'b0;
      step;
      req_valid = 1'b0;
      step;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rhold_valid: got v=%b %h exp 1 cafef00d", resp_valid, resp_rdata); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL rhold_async: got v=%b err=%b %h exp 0 0 0", resp_valid, resp_err, resp_rdata); end
      @(negedge clk);
      rst_n = 1'b1; resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rhold_after: got v=%b ready=%b exp 0 1", resp_valid, req_ready); end
      step;
   endtask

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
      test_reset;
      test_read;
      test_back_to_back;
      test_hold;
      test_write;
      test_miss;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
